// File: rtl/key_debounce_if.sv
// Push-button bundle between the board pins, the debouncer and its consumers
// (PIO in_port and the game logic).
interface key_debounce_if #(
  parameter int unsigned NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  // Board/consumer side: drives the raw pins, observes the conditioned outputs.
  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );

  // Debouncer side.
  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-flop synchroniser, stability-counter debounce and registered press/release pulses.
// Optional auto-repeat of key_press is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input logic           clk,
  input logic           reset_n,
  key_debounce_if.slave keys
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end

  logic [NUM_KEYS-1:0]  raw_norm;
  logic [NUM_KEYS-1:0]  sync1_q;
  logic [NUM_KEYS-1:0]  sync2_q;
  logic [NUM_KEYS-1:0]  stable_q;
  logic [NUM_KEYS-1:0]  stable_d;
  logic [NUM_KEYS-1:0]  differ;
  logic [NUM_KEYS-1:0]  accept;
  logic [NUM_KEYS-1:0]  press_q;
  logic [NUM_KEYS-1:0]  press_d;
  logic [NUM_KEYS-1:0]  release_q;
  logic [NUM_KEYS-1:0]  release_d;
  logic [NUM_KEYS-1:0]  rep_fire;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];

  // Normalise to pressed = 1 before synchronising so reset (0) means released.
  assign raw_norm = ACTIVE_LOW ? ~keys.key_raw : keys.key_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_norm;
      sync2_q <= sync1_q;
    end
  end

  assign differ = sync2_q ^ stable_q;

  always_comb begin
    accept    = '0;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      // Count only while the synchronised input disagrees; any agreement restarts the window.
      if (differ[k]) begin
        if (cnt_q[k] == CntLast) begin
          accept[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      stable_d[k]  = stable_q[k] ^ accept[k];
      press_d[k]   = (accept[k] & ~stable_q[k]) | rep_fire[k];
      release_d[k] = accept[k] & stable_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned          RepWidth = CNT_WIDTH + 4;
  localparam logic [RepWidth-1:0]  RepLast  = RepWidth'(REPEAT_CYCLES - 1);

  logic [RepWidth-1:0] rep_q [NUM_KEYS];
  logic [RepWidth-1:0] rep_d [NUM_KEYS];

  always_comb begin
    rep_fire = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      // A repeat never coincides with an accepted release, keeping the pulses exclusive.
      rep_fire[k] = stable_q[k] && !accept[k] && (rep_q[k] == RepLast);
      if (!stable_q[k] || accept[k] || rep_fire[k]) begin
        rep_d[k] = '0;
      end else begin
        rep_d[k] = rep_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        rep_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        rep_q[k] <= rep_d[k];
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign keys.key_level   = stable_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule
